bsram_arb_wb: RTL and testbench

//  Two-master Wishbone arbiter in front of the single-port block-RAM Wishbone slave.

---
 rtl/bsram_arb_wb_pkg.sv | 5 +
 rtl/bsram_arb_rr2.sv | 10 +
 rtl/bsram_arb_wb.sv | 89 ++++++++
 tb/tb_bsram_arb_wb.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bsram_arb_wb_pkg.sv
// bsram_arb_wb_pkg: arbiter state encodings and default timeout shared by the BSRAM Wishbone arbiter
package bsram_arb_wb_pkg;
  typedef enum logic {ARB_IDLE = 1'b0, ARB_BUSY = 1'b1} arb_state_e;
  localparam int ARB_DEF_TIMEOUT = 16;
endpackage

// File: rtl/bsram_arb_rr2.sv
// bsram_arb_rr2: 2-way round-robin pick (req[1:0], last -> grant index, valid)
module bsram_arb_rr2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       grant,
  output logic       valid
);
  assign valid = |req;
  assign grant = &req ? ~last : req[1];
endmodule

// File: rtl/bsram_arb_wb.sv
// bsram_arb_wb: round-robin two-master Wishbone arbiter in front of a BSRAM slave; m0/m1 in, s_* out, BSRAM_ARB_TIMEOUT_EN adds BUSY timeout with mN_err_o
module bsram_arb_wb
  import bsram_arb_wb_pkg::*;
#(
  parameter int AW      = 30,
  parameter int DW      = 32,
  parameter int TIMEOUT = ARB_DEF_TIMEOUT
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic [AW-1:0]   m0_adr_i,
  input  logic [DW-1:0]   m0_dat_i,
  output logic [DW-1:0]   m0_dat_o,
  input  logic            m0_we_i,
  input  logic [DW/8-1:0] m0_sel_i,
  input  logic            m0_stb_i,
  input  logic            m0_cyc_i,
  output logic            m0_ack_o,
  output logic            m0_err_o,
  input  logic [AW-1:0]   m1_adr_i,
  input  logic [DW-1:0]   m1_dat_i,
  output logic [DW-1:0]   m1_dat_o,
  input  logic            m1_we_i,
  input  logic [DW/8-1:0] m1_sel_i,
  input  logic            m1_stb_i,
  input  logic            m1_cyc_i,
  output logic            m1_ack_o,
  output logic            m1_err_o,
  output logic [AW-1:0]   s_adr_o,
  output logic [DW-1:0]   s_dat_o,
  input  logic [DW-1:0]   s_dat_i,
  output logic            s_we_o,
  output logic [DW/8-1:0] s_sel_o,
  output logic            s_stb_o,
  output logic            s_cyc_o,
  input  logic            s_ack_i
);
  arb_state_e state_q, state_d;
  logic grant_q, grant_d, last_q, last_d;
  logic pick, any_req, busy, g_req, fin, tmo;
  bsram_arb_rr2 u_rr2 (
    .req   ({m1_cyc_i & m1_stb_i, m0_cyc_i & m0_stb_i}),
    .last  (last_q),
    .grant (pick),
    .valid (any_req)
  );
  assign busy  = state_q == ARB_BUSY;
  assign g_req = grant_q ? m1_cyc_i & m1_stb_i : m0_cyc_i & m0_stb_i;
`ifdef BSRAM_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT);
  logic [TW-1:0] timer_q, timer_d;
  assign tmo = busy & g_req & ~s_ack_i & (timer_q == TW'(TIMEOUT - 1));
  always_comb timer_d = busy ? timer_q + 1'b1 : '0;
  always_ff @(posedge wb_clk_i or posedge wb_rst_i)
    if (wb_rst_i) timer_q <= '0;
    else timer_q <= timer_d;
`else
  localparam int unused_timeout = TIMEOUT;
  assign tmo = 1'b0;
`endif
  assign fin      = busy & (~g_req | s_ack_i | tmo);
  assign s_stb_o  = busy & g_req & ~tmo;
  assign s_cyc_o  = s_stb_o;
  assign s_adr_o  = grant_q ? m1_adr_i : m0_adr_i;
  assign s_dat_o  = grant_q ? m1_dat_i : m0_dat_i;
  assign s_we_o   = grant_q ? m1_we_i : m0_we_i;
  assign s_sel_o  = grant_q ? m1_sel_i : m0_sel_i;
  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;
  assign m0_ack_o = busy & g_req & s_ack_i & ~grant_q;
  assign m1_ack_o = busy & g_req & s_ack_i & grant_q;
  assign m0_err_o = tmo & ~grant_q;
  assign m1_err_o = tmo & grant_q;
  always_comb begin
    state_d = busy ? (fin ? ARB_IDLE : ARB_BUSY) : (any_req ? ARB_BUSY : ARB_IDLE);
    grant_d = (!busy && any_req) ? pick : grant_q;
    last_d  = (!busy && any_req) ? pick : last_q;
  end
  always_ff @(posedge wb_clk_i or posedge wb_rst_i)
    if (wb_rst_i) begin
      state_q <= ARB_IDLE;
      grant_q <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
endmodule

// File: tb/tb_bsram_arb_wb.sv
// tb_bsram_arb_wb: self-checking bench for bsram_arb_wb with a BSRAM slave model and transaction-level reference
module tb_bsram_arb_wb;
  localparam int AW = 30;
  localparam int DW = 32;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [AW-1:0] m0_adr_i = '0, m1_adr_i = '0, s_adr_o;
  logic [DW-1:0] m0_dat_i = '0, m1_dat_i = '0, m0_dat_o, m1_dat_o, s_dat_o, s_dat_i;
  logic [3:0] m0_sel_i = '0, m1_sel_i = '0, s_sel_o;
  logic m0_we_i = 1'b0, m1_we_i = 1'b0, m0_stb_i = 1'b0, m1_stb_i = 1'b0, m0_cyc_i = 1'b0, m1_cyc_i = 1'b0;
  logic m0_ack_o, m1_ack_o, m0_err_o, m1_err_o, s_we_o, s_stb_o, s_cyc_o;
  logic s_ack_i;
  logic mute = 1'b0;
  logic mem_clr = 1'b1;
  logic [DW-1:0] mem [256];
  logic [DW-1:0] ref_mem [256];
  int n_cmp = 0;
  int n_bad = 0;
  always #5 clk = ~clk;
  bsram_arb_wb #(.AW(AW), .DW(DW), .TIMEOUT(4)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_dat_o(m0_dat_o), .m0_we_i(m0_we_i), .m0_sel_i(m0_sel_i),
    .m0_stb_i(m0_stb_i), .m0_cyc_i(m0_cyc_i), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_dat_o(m1_dat_o), .m1_we_i(m1_we_i), .m1_sel_i(m1_sel_i),
    .m1_stb_i(m1_stb_i), .m1_cyc_i(m1_cyc_i), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
    .s_stb_o(s_stb_o), .s_cyc_o(s_cyc_o), .s_ack_i(s_ack_i)
  );
  initial s_ack_i = 1'b0;
  initial s_dat_i = '0;
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= '0;
      s_ack_i <= 1'b0;
    end else if (s_stb_o && s_cyc_o && !s_ack_i && !mute) begin
      s_ack_i <= 1'b1;
      s_dat_i <= mem[s_adr_o[7:0]];
      if (s_we_o)
        for (int b = 0; b < 4; b++)
          if (s_sel_o[b]) mem[s_adr_o[7:0]][8*b +: 8] <= s_dat_o[8*b +: 8];
    end else s_ack_i <= 1'b0;
  end
  initial begin
    #400000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1);
  end
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask
  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
    for (int b = 0; b < 4; b++) if (s[b]) o[8*b +: 8] = n[8*b +: 8];
    return o;
  endfunction
  task automatic drive(input logic mst, input logic req, input logic we, input logic [AW-1:0] adr,
                       input logic [31:0] dat, input logic [3:0] sel);
    if (mst) begin
      m1_cyc_i = req; m1_stb_i = req; m1_we_i = we; m1_adr_i = adr; m1_dat_i = dat; m1_sel_i = sel;
    end else begin
      m0_cyc_i = req; m0_stb_i = req; m0_we_i = we; m0_adr_i = adr; m0_dat_i = dat; m0_sel_i = sel;
    end
  endtask
  task automatic do_reset();
    drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
    drive(1'b1, 1'b0, 1'b0, '0, '0, '0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask
  task automatic do_tx(input logic mst, input logic we, input logic [AW-1:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel, output int stb_lat, output int ack_lat, output int own_acks,
                       output int oth_acks, output logic [31:0] rd);
    stb_lat = 0; ack_lat = 0; own_acks = 0; oth_acks = 0; rd = '0;
    @(posedge clk); #1;
    drive(mst, 1'b1, we, adr, dat, sel);
    for (int i = 1; i <= 10 && ack_lat == 0; i++) begin
      @(negedge clk);
      if (s_stb_o && stb_lat == 0) stb_lat = i;
      if (mst ? m1_ack_o : m0_ack_o) begin
        ack_lat = i; own_acks++; rd = mst ? m1_dat_o : m0_dat_o;
      end
      if (mst ? m0_ack_o : m1_ack_o) oth_acks++;
    end
    @(posedge clk); #1;
    drive(mst, 1'b0, 1'b0, '0, '0, '0);
    repeat (3) begin
      @(negedge clk);
      if (mst ? m1_ack_o : m0_ack_o) own_acks++;
      if (mst ? m0_ack_o : m1_ack_o) oth_acks++;
    end
  endtask
  typedef struct {
    logic mst; logic we; logic [AW-1:0] adr; logic [31:0] dat; logic [3:0] sel; logic [31:0] exp_rd;
  } vec_t;
  vec_t vt[8];
  initial begin
    int sl, al, oa, xa, k, n_err, first;
    logic [31:0] rd;
    logic [AW:0] snap;
    int who[6], when[6];
    logic pend[2], p_we[2], prev_sack, ack;
    logic [AW-1:0] p_adr[2];
    logic [31:0] p_dat[2];
    logic [3:0] p_sel[2];
    int age[2], oth[2];
    vt[0] = '{1'b0, 1'b1, AW'('h10), 32'hDEADBEEF, 4'hF, 32'h0};
    vt[1] = '{1'b1, 1'b0, AW'('h10), 32'h0,        4'hF, 32'hDEADBEEF};
    vt[2] = '{1'b0, 1'b1, AW'('h10), 32'h0000AB00, 4'h2, 32'h0};
    vt[3] = '{1'b0, 1'b0, AW'('h10), 32'h0,        4'hF, 32'hDEADABEF};
    vt[4] = '{1'b1, 1'b1, AW'('h3),  32'h12345678, 4'hF, 32'h0};
    vt[5] = '{1'b0, 1'b0, AW'('h3),  32'h0,        4'hF, 32'h12345678};
    vt[6] = '{1'b1, 1'b1, AW'('h3),  32'hFFFFFFFF, 4'h9, 32'h0};
    vt[7] = '{1'b1, 1'b0, AW'('h3),  32'h0,        4'hF, 32'hFF3456FF};
    drive(1'b0, 1'b1, 1'b1, AW'('h10), 32'h1, 4'hF);
    drive(1'b1, 1'b1, 1'b0, AW'('h20), 32'h2, 4'hF);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", {s_cyc_o, s_stb_o, m0_ack_o, m1_ack_o, m0_err_o, m1_err_o}, 6'b0);
    #1 mem_clr = 1'b0;
    do_reset();
    for (int v = 0; v < 8; v++) begin
      do_tx(vt[v].mst, vt[v].we, vt[v].adr, vt[v].dat, vt[v].sel, sl, al, oa, xa, rd);
      chk($sformatf("vec%0d_stb_lat", v), sl, 2);
      chk($sformatf("vec%0d_ack_lat", v), al, 3);
      chk($sformatf("vec%0d_own_acks", v), oa, 1);
      chk($sformatf("vec%0d_other_acks", v), xa, 0);
      if (!vt[v].we) chk($sformatf("vec%0d_rdata", v), rd, vt[v].exp_rd);
    end
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 1'b0, AW'('h10), '0, 4'hF);
    @(negedge clk); chk("abort_idle_stb", s_stb_o, 1'b0);
    @(negedge clk); chk("abort_busy_stb", s_stb_o, 1'b1);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
    drive(1'b1, 1'b1, 1'b0, AW'('h3), '0, 4'hF);
    @(negedge clk); chk("abort_ack_blocked", {s_ack_i, s_stb_o, m0_ack_o, m1_ack_o}, 4'b1000);
    @(negedge clk); chk("abort_gap_stb", s_stb_o, 1'b0);
    @(negedge clk); chk("abort_regrant", {s_stb_o, s_adr_o}, {1'b1, AW'('h3)});
    @(negedge clk); chk("abort_m1_ack", {m1_ack_o, m0_ack_o, m1_dat_o}, {2'b10, 32'hFF3456FF});
    @(posedge clk); #1 drive(1'b1, 1'b0, 1'b0, '0, '0, '0);
    @(posedge clk); #1 drive(1'b1, 1'b1, 1'b0, AW'('h10), '0, 4'hF);
    @(negedge clk); @(negedge clk);
    chk("rst_mid_pre", s_stb_o, 1'b1);
    rst = 1'b1;
    #1 chk("rst_mid_async", {s_cyc_o, s_stb_o, m1_ack_o}, 3'b0);
    @(negedge clk); chk("rst_mid_noack", {s_stb_o, m1_ack_o, m0_ack_o}, 3'b0);
    do_reset();
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 1'b0, AW'('h10), '0, 4'hF);
    drive(1'b1, 1'b1, 1'b0, AW'('h3), '0, 4'hF);
    k = 0;
    for (int i = 0; i < 6; i++) begin who[i] = 3; when[i] = 0; end
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (m0_ack_o || m1_ack_o) begin
        if (k < 6) begin
          who[k] = (m0_ack_o && m1_ack_o) ? 2 : int'(m1_ack_o);
          when[k] = i;
        end
        k++;
      end
    end
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("alt_who%0d", i), who[i], i % 2);
      chk($sformatf("alt_when%0d", i), when[i], 3 * (i + 1));
    end
    do_reset();
    mute = 1'b1;
`ifdef BSRAM_ARB_TIMEOUT_EN
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 1'b0, AW'('h5), '0, 4'hF);
    drive(1'b1, 1'b1, 1'b0, AW'('h6), '0, 4'hF);
    n_err = 0; first = 0; snap = '0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (m0_err_o) begin n_err++; if (first == 0) first = i; end
      if (i == 7) snap = {s_stb_o, s_adr_o};
    end
    chk("tmo_m0_err_count", n_err, 1);
    chk("tmo_m0_err_cycle", first, 5);
    chk("tmo_m1_granted", snap, {1'b1, AW'('h6)});
`else
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 1'b0, AW'('h5), '0, 4'hF);
    n_err = 0;
    repeat (20) begin
      @(negedge clk);
      if (m0_err_o || m1_err_o || m0_ack_o) n_err++;
    end
    chk("hang_no_err_ack", n_err, 0);
    chk("hang_stb_held", s_stb_o, 1'b1);
`endif
    do_reset();
    mute = 1'b0;
    mem_clr = 1'b1;
    @(posedge clk); #1 mem_clr = 1'b0;
    for (int i = 0; i < 256; i++) ref_mem[i] = '0;
    for (int m = 0; m < 2; m++) begin
      pend[m] = 1'b0; p_we[m] = 1'b0; p_adr[m] = '0; p_dat[m] = '0; p_sel[m] = '0; age[m] = 0; oth[m] = 0;
    end
    prev_sack = 1'b0;
    for (int c = 0; c < 600; c++) begin
      @(posedge clk); #1;
      for (int m = 0; m < 2; m++) begin
        if (!pend[m] && $urandom_range(0, 2) != 0) begin
          p_we[m] = 1'($urandom_range(0, 1));
          p_adr[m] = AW'($urandom_range(0, 7));
          p_dat[m] = $urandom;
          p_sel[m] = 4'($urandom_range(1, 15));
          pend[m] = 1'b1; age[m] = 0; oth[m] = 0;
        end
        drive(1'(m), pend[m], p_we[m], p_adr[m], p_dat[m], p_sel[m]);
      end
      @(negedge clk);
      if (prev_sack) chk("rand_stb_drop_after_ack", s_stb_o, 1'b0);
      prev_sack = s_ack_i;
      chk("rand_single_ack", m0_ack_o & m1_ack_o, 1'b0);
      for (int m = 0; m < 2; m++) begin
        ack = m ? m1_ack_o : m0_ack_o;
        if (pend[m]) age[m]++;
        if (ack) begin
          chk($sformatf("rand_m%0d_ack_pending", m), pend[m], 1'b1);
          if (pend[m]) begin
            if (!p_we[m]) chk($sformatf("rand_m%0d_rdata", m), m ? m1_dat_o : m0_dat_o, ref_mem[p_adr[m][7:0]]);
            else ref_mem[p_adr[m][7:0]] = merge(ref_mem[p_adr[m][7:0]], p_dat[m], p_sel[m]);
            chk($sformatf("rand_m%0d_wait_le6", m), age[m] <= 6, 1'b1);
            chk($sformatf("rand_m%0d_fair", m), oth[m] <= 1, 1'b1);
            if (pend[1-m]) oth[1-m]++;
            pend[m] = 1'b0;
          end
        end else if (pend[m] && age[m] > 8) begin
          chk($sformatf("rand_m%0d_stall", m), age[m], 8);
          pend[m] = 1'b0;
        end
      end
    end
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
    drive(1'b1, 1'b0, 1'b0, '0, '0, '0);
    repeat (4) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
